// File: rtl/clockworks_ctrl.sv
// clockworks_ctrl: core clock-enable generator and staged reset sequencer.
//
// After RESET is released (through a 2-flop synchroniser), the block holds
// every reset domain for POR_CYCLES cycles. It then releases the domains in
// index order, STAGE_GAP cycles apart. Once every domain is out of reset,
// it produces a core clock-enable in one of these modes: full speed,
// divide-by-(D+1), single-step from a button, or hold.
//
// Ports:
//   CLK        board clock
//   RESET      asynchronous, active-low board reset
//   mode       00 run, 01 divided, 10 single-step, 11 hold
//   div_load   one-cycle strobe, loads div_value into the divide register
//   div_value  divide value D, clk_en period is D+1 cycles
//   step       asynchronous step button (level)
//   clk_en     registered core clock enable
//   resetn     per-domain active-low resets, bit 0 released first
//   por_done   high once all domains are released
//
// state   | meaning
// --------+-------------------------------------------------
// S_POR   | power-on hold-off, all domains in reset
// S_STAGE | releasing domains one by one, STAGE_GAP apart
// S_RUN   | all domains released, clk_en follows mode
module clockworks_ctrl #(
  parameter int NUM_RST    = 2,
  parameter int POR_CYCLES = 4096,
  parameter int STAGE_GAP  = 16,
  parameter int DIV_W      = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         mode,
  input  logic               div_load,
  input  logic [DIV_W-1:0]   div_value,
  input  logic               step,
  output logic               clk_en,
  output logic [NUM_RST-1:0] resetn,
  output logic               por_done
);

  localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [1:0] {S_POR, S_STAGE, S_RUN} state_t;

  // Async assert, sync release. rst_n is a flop output, so it is a clean
  // reset for the rest of the block.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t             state_q, state_d;
  logic [POR_W-1:0]   por_cnt_q, por_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_RST-1:0] resetn_q, resetn_d;
  logic               por_done_q, por_done_d;
  logic               clk_en_q, clk_en_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         mode_q;
  logic [1:0]         step_sync_q;
  logic               step_prev_q;
  logic               pend_q, pend_d;
  logic               mode_chg;
  logic               step_rise;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_POR;
      por_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      resetn_q    <= '0;
      por_done_q  <= 1'b0;
      clk_en_q    <= 1'b0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      mode_q      <= 2'b00;
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      resetn_q    <= resetn_d;
      por_done_q  <= por_done_d;
      clk_en_q    <= clk_en_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      mode_q      <= mode;
      step_sync_q <= {step_sync_q[0], step};
      step_prev_q <= step_sync_q[1];
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    resetn_d   = resetn_q;
    por_done_d = por_done_q;
    clk_en_d   = 1'b0;
    div_d      = div_q;
    div_cnt_d  = '0;
    pend_d     = 1'b0;
    mode_chg   = (mode != mode_q);
    step_rise  = step_sync_q[1] & ~step_prev_q;

    if (div_load) div_d = div_value;

    case (state_q)
      S_POR: begin
        if (por_cnt_q == POR_LAST) begin
          resetn_d = NUM_RST'(1);
          if (NUM_RST == 1) begin
            state_d    = S_RUN;
            por_done_d = 1'b1;
          end else begin
            state_d   = S_STAGE;
            gap_cnt_d = GAP_LAST;
          end
        end else begin
          por_cnt_d = por_cnt_q + 1'b1;
        end
      end
      S_STAGE: begin
        if (&resetn_q) begin
          state_d    = S_RUN;
          por_done_d = 1'b1;
        end else if (gap_cnt_q == '0) begin
          // Domains release in index order, so resetn is a thermometer code.
          resetn_d  = (resetn_q << 1) | NUM_RST'(1);
          gap_cnt_d = GAP_LAST;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        // A mode change leaves the divide counter and the pending step at
        // their cleared defaults. Only run mode enables on that edge.
        if (mode_chg) begin
          clk_en_d = (mode == MODE_RUN);
        end else begin
          case (mode)
            MODE_RUN: clk_en_d = 1'b1;
            MODE_DIV: begin
              // A load restarts the period and drops any pulse due now.
              if (!div_load) begin
                if (div_cnt_q == div_q) clk_en_d = 1'b1;
                else                    div_cnt_d = div_cnt_q + 1'b1;
              end
            end
            MODE_STEP: begin
              clk_en_d = pend_q;
              pend_d   = step_rise;
            end
            default: clk_en_d = 1'b0;
          endcase
        end
      end
      default: state_d = S_POR;
    endcase
  end

  assign clk_en   = clk_en_q;
  assign resetn   = resetn_q;
  assign por_done = por_done_q;

endmodule

// File: tb/tb_clockworks_ctrl.sv
module tb_clockworks_ctrl;

  localparam int NUM_RST    = 3;
  localparam int POR_CYCLES = 8;
  localparam int STAGE_GAP  = 4;
  localparam int DIV_W      = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       mode;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             step;
  logic             clk_en;
  logic [NUM_RST-1:0] resetn;
  logic             por_done;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  bit exp_q[$];

  clockworks_ctrl #(
    .NUM_RST(NUM_RST), .POR_CYCLES(POR_CYCLES),
    .STAGE_GAP(STAGE_GAP), .DIV_W(DIV_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .mode(mode), .div_load(div_load),
    .div_value(div_value), .step(step), .clk_en(clk_en),
    .resetn(resetn), .por_done(por_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_const(input int n, input bit v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Expected clk_en: first pulse at sample index 'first', then every 'period'.
  task automatic push_div(input int n, input int first, input int period);
    for (int i = 0; i < n; i++)
      exp_q.push_back((i >= first) && (((i - first) % period) == 0));
  endtask

  task automatic drain_n(input string tag, input int n);
    bit e;
    for (int i = 0; i < n; i++) begin
      cycle();
      e = exp_q.pop_front();
      if (clk_en === 1'b1) pulse_cnt++;
      check(tag, 32'(clk_en), 32'(e));
    end
  endtask

  task automatic drain(input string tag);
    drain_n(tag, exp_q.size());
  endtask

  // Release RESET right after an edge (edge 0) and follow the sequence for
  // n edges: resetn bits at 2+POR, +GAP, +GAP; por_done one edge later.
  task automatic por_seq(input string tag, input int n, input bit toggle);
    logic [NUM_RST-1:0] er;
    RESET = 1'b1;
    for (int e = 1; e <= n; e++) begin
      cycle();
      er = '0;
      for (int k = 0; k < NUM_RST; k++)
        if (e >= 2 + POR_CYCLES + k * STAGE_GAP) er[k] = 1'b1;
      check({tag, "_resetn"}, 32'(resetn), 32'(er));
      check({tag, "_por_done"}, 32'(por_done),
            32'(e >= 2 + POR_CYCLES + (NUM_RST - 1) * STAGE_GAP + 1));
      if (e <= 2 + POR_CYCLES + (NUM_RST - 1) * STAGE_GAP + 1)
        check({tag, "_clk_en"}, 32'(clk_en), 32'(0));
      if (toggle) step = (e < 8) ? e[0] : 1'b0;
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 RESET = 1'b0;
    #1;
    check({tag, "_resetn"}, 32'(resetn), 32'(0));
    check({tag, "_clk_en"}, 32'(clk_en), 32'(0));
    check({tag, "_por_done"}, 32'(por_done), 32'(0));
  endtask

  initial begin
    RESET = 1'b0; mode = 2'b10; div_load = 1'b0; div_value = '0; step = 1'b0;
    #3;
    check("rst_resetn", 32'(resetn), 32'(0));
    check("rst_clk_en", 32'(clk_en), 32'(0));
    check("rst_por_done", 32'(por_done), 32'(0));
    cycle(); cycle(); cycle();

    // Power-on sequence with step toggling during S_POR
    por_seq("por", 20, 1'b1);
    push_const(8, 1'b0);
    drain("por_step_discard");

    // Single-step: held high 50 cycles, low, high again
    pulse_cnt = 0;
    step = 1'b1; push_div(50, 3, 1000); drain("step_first");
    step = 1'b0; push_const(6, 1'b0);   drain("step_low");
    step = 1'b1; push_div(10, 3, 1000); drain("step_second");
    step = 1'b0;
    check("step_pulse_count", 32'(pulse_cnt), 32'(2));

    // Mode switching
    mode = 2'b00; push_const(5, 1'b1); drain("run_enter");
    mode = 2'b11; push_const(5, 1'b0); drain("hold_enter");
    div_load = 1'b1; div_value = 8'd1; push_const(1, 1'b0); drain("hold_load");
    div_load = 1'b0;
    mode = 2'b01; push_div(9, 2, 2); drain("div1_enter");

    // Divide by D=3, then D=0
    div_load = 1'b1; div_value = 8'd3; push_div(13, 4, 4);
    drain_n("div3", 1); div_load = 1'b0; drain("div3");
    div_load = 1'b1; div_value = 8'd0; push_div(8, 1, 1);
    drain_n("div0", 1); div_load = 1'b0; drain("div0");

    // Reload D=2 exactly when the D=9 counter reaches its terminal count
    div_load = 1'b1; div_value = 8'd9; push_const(10, 1'b0);
    drain_n("div9", 1); div_load = 1'b0; drain("div9");
    div_load = 1'b1; div_value = 8'd2; push_div(8, 3, 3);
    drain_n("reload", 1); div_load = 1'b0; drain("reload");

    // Largest divide value: period 2^DIV_W
    div_load = 1'b1; div_value = 8'hFF; push_div(520, 256, 256);
    drain_n("divmax", 1); div_load = 1'b0; drain("divmax");

    // Async reset mid S_RUN with clk_en high
    mode = 2'b00; push_const(4, 1'b1); drain("run_pre_rst");
    async_reset_check("run_async");
    mode = 2'b01;
    cycle(); cycle();

    // Async reset mid S_STAGE
    por_seq("reseq1", 12, 1'b0);
    async_reset_check("stage_async");
    cycle(); cycle();

    // Full resequence; divide register is back to 0, so clk_en stays high
    por_seq("reseq2", 20, 1'b0);
    push_const(6, 1'b1); drain("div_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
